// File: rtl/wb_pkg.sv
// Shared Wishbone host definitions: bridge FSM states, bus widths and the
// harness register map used by benches and command front-ends.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUS  = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_ADR_W-1:0] HARNESS_ACTIVE_ADR = 32'h3000_0000;
  localparam logic [WB_ADR_W-1:0] HARNESS_OEB0_ADR   = 32'h3000_0004;
  localparam logic [WB_ADR_W-1:0] HARNESS_OEB1_ADR   = 32'h3000_0008;
  localparam logic [WB_ADR_W-1:0] HARNESS_WS2812_ADR = 32'h3000_0100;
  localparam logic [WB_ADR_W-1:0] HARNESS_7SEG_ADR   = 32'h3000_0200;
  localparam logic [WB_ADR_W-1:0] HARNESS_FREQ_ADR   = 32'h3000_0400;
  localparam logic [WB_ADR_W-1:0] HARNESS_WATCH_ADR  = 32'h3000_0500;

endpackage

// File: rtl/wb_host_bridge.sv
// Wishbone classic initiator: one bus cycle per accepted request, with a
// bounded timeout so unmapped addresses still produce an (error) response.
module wb_host_bridge
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [WB_SEL_W-1:0]  req_sel_i,
  input  logic [WB_ADR_W-1:0]  req_adr_i,
  input  logic [WB_DAT_W-1:0]  req_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WB_DAT_W-1:0]  rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [WB_SEL_W-1:0]  wbm_sel_o,
  output logic [WB_ADR_W-1:0]  wbm_adr_o,
  output logic [WB_DAT_W-1:0]  wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic [WB_DAT_W-1:0]  wbm_dat_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  wb_state_e             state_reg, state_next;
  logic [TIMER_W-1:0]    timer_reg, timer_next;
  logic                  cyc_reg, cyc_next;
  logic                  we_reg, we_next;
  logic [WB_SEL_W-1:0]   sel_reg, sel_next;
  logic [WB_ADR_W-1:0]   adr_reg, adr_next;
  logic [WB_DAT_W-1:0]   dat_reg, dat_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [WB_DAT_W-1:0]   rsp_dat_reg, rsp_dat_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic [ERR_CNT_W-1:0]  err_cnt_reg, err_cnt_next;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg     <= ST_INIT;
      timer_reg     <= '0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      rsp_err_reg   <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      cyc_reg       <= cyc_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      adr_reg       <= adr_next;
      dat_reg       <= dat_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_dat_reg   <= rsp_dat_next;
      rsp_err_reg   <= rsp_err_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    cyc_next       = cyc_reg;
    we_next        = we_reg;
    sel_next       = sel_reg;
    adr_next       = adr_reg;
    dat_next       = dat_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_dat_next   = rsp_dat_reg;
    rsp_err_next   = rsp_err_reg;
    err_cnt_next   = err_cnt_reg;

    case (state_reg)
      ST_INIT: state_next = ST_IDLE;

      ST_IDLE: begin
        if (req_valid_i) begin
          cyc_next   = 1'b1;
          we_next    = req_we_i;
          sel_next   = req_sel_i;
          adr_next   = req_adr_i;
          dat_next   = req_we_i ? req_dat_i : '0;
          timer_next = '0;
          state_next = ST_BUS;
        end
      end

      ST_BUS: begin
        // Ack is checked before the timeout so a late ack still wins.
        if (wbm_ack_i) begin
          rsp_dat_next   = we_reg ? '0 : wbm_dat_i;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          cyc_next       = 1'b0;
          state_next     = ST_RESP;
        end else if (timer_reg == TIMER_LAST) begin
          rsp_dat_next   = '0;
          rsp_err_next   = 1'b1;
          rsp_valid_next = 1'b1;
          cyc_next       = 1'b0;
          if (err_cnt_reg != {ERR_CNT_W{1'b1}}) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
          end
          state_next     = ST_RESP;
        end else begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: state_next = ST_INIT;
    endcase
  end

  assign req_ready_o = (state_reg == ST_IDLE);
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_dat_o   = rsp_dat_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign wbm_cyc_o   = cyc_reg;
  assign wbm_stb_o   = cyc_reg;
  assign wbm_we_o    = we_reg;
  assign wbm_sel_o   = sel_reg;
  assign wbm_adr_o   = adr_reg;
  assign wbm_dat_o   = dat_reg;
  assign err_cnt_o   = err_cnt_reg;

endmodule

// File: doc/wb_host_bridge.md
Name: wb_host_bridge

Overview:
- Wishbone classic initiator: turns single-beat requests from a simple valid/ready command port into one Wishbone cycle each, then returns read data and a status on a valid/ready response port.
- Sits upstream of the multi-project harness slave port. Used as the bus driver for harness-level benches, and as the on-chip host for command front-ends such as UART and SPI.
- Unmapped harness addresses never ack, so a bounded timeout is mandatory.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of cycles the bus cycle may stay open without ack. Legal range 2..65535.
- ERR_CNT_W, 8: width of the saturating timeout counter.

Ports:
- wb_clk_i in 1: clock.
- wb_rst_n_i in 1: asynchronous active-low reset.
- req_valid_i in 1: request valid.
- req_ready_o out 1: request accepted when valid & ready.
- req_we_i in 1: 1 = write, 0 = read.
- req_sel_i in 4: byte selects.
- req_adr_i in 32: byte address.
- req_dat_i in 32: write data.
- rsp_valid_o out 1: response valid.
- rsp_ready_i in 1: response consumed when valid & ready.
- rsp_dat_o out 32: read data; 0 for writes and on timeout.
- rsp_err_o out 1: 1 = timeout.
- wbm_cyc_o out 1: Wishbone cycle.
- wbm_stb_o out 1: Wishbone strobe.
- wbm_we_o out 1: Wishbone write enable.
- wbm_sel_o out 4: Wishbone byte selects.
- wbm_adr_o out 32: Wishbone address.
- wbm_dat_o out 32: Wishbone write data.
- wbm_ack_i in 1: Wishbone acknowledge.
- wbm_dat_i in 32: Wishbone read data.
- err_cnt_o out ERR_CNT_W: count of timeouts, saturating.

Behaviour:
- Reset (async assert, sync release): every output is 0, state = INIT, timer = 0, err_cnt = 0. Wishbone outputs and rsp_* are registered.
- States: INIT -> IDLE -> BUS -> RESP -> IDLE.
- INIT: lasts exactly one cycle after reset release; req_ready_o = 0.
- IDLE: req_ready_o = 1 (combinational from state).
  - On req_valid_i, latch we/sel/adr/dat. Next edge: cyc = stb = 1, drive the latched fields, enter BUS with timer = 0.
  - wbm_dat_o is 0 for reads.
- BUS: req_ready_o = 0.
  - wbm_ack_i is sampled every BUS cycle, including the first.
  - On ack: capture rsp_dat = we ? 0 : wbm_dat_i, rsp_err = 0, rsp_valid = 1, cyc = stb = 0; go to RESP.
  - Otherwise timer increments. When timer == TIMEOUT_CYCLES-1 and no ack: rsp_err = 1, rsp_dat = 0, rsp_valid = 1, cyc = stb = 0, err_cnt increments (saturates at all-ones); go to RESP.
  - A bus cycle therefore lasts 1..TIMEOUT_CYCLES cycles.
  - Ack in the timeout cycle: ack wins, err = 0.
- Address, data, sel and we stay stable for the whole of BUS. cyc and stb are always equal.
- RESP: rsp_valid_o held with stable data until rsp_ready_i, then clear rsp_valid and go to IDLE.
  - rsp_ready_i high in the first RESP cycle still costs that one cycle.
- wbm_ack_i is ignored outside BUS. A registered-ack slave still shows ack in the cycle after stb drops. RESP plus IDLE guarantee at least 2 idle bus cycles between transactions, so a stale ack can never complete the next cycle.
- Minimum latency, accept to rsp_valid with a 1-cycle-ack slave: 2 cycles. With the harness's registered ack: 3 cycles.
- Reset mid-BUS: cyc/stb drop asynchronously, the in-flight request and any pending response are discarded, and no response is issued.
- Back-to-back requests: only one outstanding; the next request waits until IDLE.

Decomposition:
- Shared package wb_pkg holds:
  - the state enum (INIT, IDLE, BUS, RESP);
  - WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4;
  - harness address constants 0x30000000 (active), 0x30000004/0x30000008 (oeb), 0x30000100 (ws2812), 0x30000200 (7seg), 0x30000400 (freq), 0x30000500 (watch), so benches and command front-ends share them.
- No sub-module; the timer and err counter stay inline. Timer width is $clog2(TIMEOUT_CYCLES).

Test Plan:
- Write 0x00000003 to 0x30000000, sel 0xF, against the harness -> one cyc/stb pulse held until ack; rsp_valid with err = 0, dat = 0; harness active_project = 3.
- Read 0x30000000 after that write -> rsp_dat_o = 0x00000003, err = 0; wbm_dat_o = 0 and wbm_we_o = 0 during the cycle.
- Write to unmapped 0x30000300 -> cyc high for exactly 255 cycles, then rsp_err_o = 1, rsp_dat_o = 0, err_cnt_o = 1. Repeat 300 times -> err_cnt_o saturates at 255.
- Two requests presented back to back, rsp_ready_i tied high -> the second is accepted only in IDLE; at least 2 idle cycles between cyc pulses; the held-over harness ack does not complete the second cycle.
- rsp_ready_i held low 10 cycles after a read -> rsp_valid_o and rsp_dat_o stable throughout; req_ready_o = 0 until the response is consumed.
- Assert wb_rst_n_i mid-BUS (cycle 5 of a timeout-bound cycle) -> cyc/stb go 0 immediately, no response issued, err_cnt_o = 0; after release, INIT for one cycle with req_ready_o = 0, then IDLE with req_ready_o = 1.
